// File: rtl/npu_sequencer.sv
// Convolution job sequencer: walks N output positions x S accumulation steps,
// issuing nine 3x3-window read addresses plus bias/PE/post-processing controls.
module npu_sequencer #(
   parameter int width     = 80,
   parameter int height    = 8,
   parameter int width_b   = 7,
   parameter int height_b  = 3,
   parameter int DRAIN_CYC = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    hold,
   input  logic [width_b-1:0]      cfg_base_w,
   input  logic [width_b-1:0]      cfg_num_out,
   input  logic [2:0]              cfg_steps,
   input  logic [2:0]              cfg_bound,
   input  logic                    cfg_relu,
   input  logic                    cfg_mp,
   output logic [width_b*9-1:0]    readi_w,
   output logic [height_b*9-1:0]   readi_h,
   output logic [8:0]              en_read,
   output logic                    en_bias,
   output logic [2:0]              step,
   output logic                    en_pe,
   output logic [2:0]              step_p,
   output logic [2:0]              bound_level,
   output logic                    en_relu,
   output logic                    en_mp,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [2:0]              state_dbg
);
   // Handshake: start is a single-cycle request taken only while busy=0 (anything
   // else is dropped); hold stalls RUN for every cycle it is high and is ignored elsewhere.

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BIAS  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   state_t             state, state_n;
   logic [width_b-1:0] p, base_q, num_q;
   logic [2:0]         s, steps_q, bound_q;
   logic               relu_q, mp_q, err_q;
   logic [DW-1:0]      drain_cnt;
   logic               cfg_bad, s_last, p_last, drain_last;

   // The rightmost lane of the last window reads column base+N+1, which must exist.
   assign cfg_bad    = (32'(cfg_base_w) + 32'(cfg_num_out) + 32'd1) > 32'(width - 1);
   assign s_last     = (s == steps_q);
   assign p_last     = (p == num_q - 1'b1);
   assign drain_last = (drain_cnt == DW'(DRAIN_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         p         <= '0;
         s         <= '0;
         drain_cnt <= '0;
         base_q    <= '0;
         num_q     <= '0;
         steps_q   <= '0;
         bound_q   <= '0;
         relu_q    <= 1'b0;
         mp_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state <= state_n;
         err_q <= (state == IDLE) && start && cfg_bad;
         case (state)
            IDLE: begin
               if (start) begin
                  base_q    <= cfg_base_w;
                  num_q     <= cfg_num_out;
                  steps_q   <= cfg_steps;
                  bound_q   <= cfg_bound;
                  relu_q    <= cfg_relu;
                  mp_q      <= cfg_mp;
                  p         <= '0;
                  s         <= '0;
                  drain_cnt <= '0;
               end
            end
            RUN: begin
               if (!hold) begin
                  if (s_last) begin
                     s <= '0;
                     p <= p + 1'b1;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            DRAIN:   drain_cnt <= drain_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_bad)                state_n = IDLE;
               else if (cfg_num_out == '0) state_n = DONE;
               else                        state_n = BIAS;
            end
         end
         BIAS:    state_n = RUN;
         RUN:     if (!hold && s_last && p_last) state_n = DRAIN;
         DRAIN:   if (drain_last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      readi_w     = '0;
      readi_h     = '0;
      en_read     = '0;
      en_bias     = 1'b0;
      step        = '0;
      en_pe       = 1'b0;
      step_p      = '0;
      bound_level = '0;
      en_relu     = 1'b0;
      en_mp       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      state_dbg   = '0;
      if (!reset) begin
         state_dbg = state;
         busy      = (state != IDLE);
         err       = err_q;
         if (state != IDLE) begin
            bound_level = bound_q;
            en_relu     = relu_q;
            en_mp       = mp_q;
         end
         case (state)
            BIAS: en_bias = 1'b1;
            RUN: begin
               step   = s;
               step_p = s;
               // Lane k covers window column k%3 and row k/3; lane 0 sits in the top slice.
               for (int k = 0; k < 9; k++) begin
                  readi_w[(8-k)*width_b +: width_b] =
                     width_b'(32'(base_q) + 32'(p) + 32'(k % 3));
                  readi_h[(8-k)*height_b +: height_b] =
                     height_b'((32'(s) + 32'(k / 3)) % 32'(height));
               end
               if (!hold) begin
                  en_read = 9'h1FF;
                  en_pe   = 1'b1;
               end
            end
            DONE:    done = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_npu_sequencer.sv
// Bench for npu_sequencer: job table, directed multi-cycle sequences and random
// traffic, every cycle compared against a work-count reference model.
module tb_npu_sequencer;
   localparam int W_B   = 7;
   localparam int H_B   = 3;
   localparam int COLS  = 80;
   localparam int ROWS  = 8;
   localparam int DRAIN = 4;
   localparam int TR    = 512;
   localparam int VW    = 115;

   logic             clk = 1'b0;
   logic             reset, start, hold;
   logic [W_B-1:0]   cfg_base_w, cfg_num_out;
   logic [2:0]       cfg_steps, cfg_bound;
   logic             cfg_relu, cfg_mp;
   logic [W_B*9-1:0] readi_w;
   logic [H_B*9-1:0] readi_h;
   logic [8:0]       en_read;
   logic             en_bias, en_pe, en_relu, en_mp, busy, done, err;
   logic [2:0]       step, step_p, bound_level, state_dbg;
   logic [VW-1:0]    act;

   npu_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .hold(hold),
      .cfg_base_w(cfg_base_w), .cfg_num_out(cfg_num_out), .cfg_steps(cfg_steps),
      .cfg_bound(cfg_bound), .cfg_relu(cfg_relu), .cfg_mp(cfg_mp),
      .readi_w(readi_w), .readi_h(readi_h), .en_read(en_read), .en_bias(en_bias),
      .step(step), .en_pe(en_pe), .step_p(step_p), .bound_level(bound_level),
      .en_relu(en_relu), .en_mp(en_mp), .busy(busy), .done(done), .err(err),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   assign act = {readi_w, readi_h, en_read, en_bias, step, en_pe, step_p,
                 bound_level, en_relu, en_mp, busy, done, err};

   int n_checks = 0;
   int n_err    = 0;
   logic [VW-1:0] exp_q[$];

   // reference model: job progress as a count of finished PE cycles
   int m_active = 0, m_err_pend = 0, m_zero = 0, m_bias_done = 0;
   int m_work = 0, m_drain = 0, m_base = 0, m_n = 0, m_s = 1;
   int m_bound = 0, m_relu = 0, m_mp = 0;

   // per-job trace
   int cyc = 0, total_cyc = 0;
   int pe_cnt, rd_cnt, busy_cnt, done_cnt, err_cnt, done_at, err_at;
   logic [W_B*9-1:0] tr_w[TR];
   logic [H_B*9-1:0] tr_h[TR];
   logic             tr_pe[TR];
   logic             tr_bias[TR];
   logic [VW-1:0]    tr_act[TR];
   logic [2:0]       tr_state[TR];

   typedef struct {
      int base; int n; int steps;
      int busy_c; int pe_c; int done_c; int err_c; int done_at; int err_at;
   } job_vec_t;
   job_vec_t tbl[8];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [VW-1:0] model_out(input logic r, input logic h);
      logic [W_B*9-1:0] w;
      logic [H_B*9-1:0] hh;
      logic [8:0] er;
      logic [2:0] st, bl;
      logic eb, ep, rl, mp, bz, dn, eo;
      int p, s;
      w = '0; hh = '0; er = '0; st = '0; bl = '0;
      eb = 0; ep = 0; rl = 0; mp = 0; bz = 0; dn = 0; eo = 0;
      if (!r) begin
         if (m_active == 0) begin
            eo = (m_err_pend != 0);
         end else begin
            bz = 1; bl = 3'(m_bound); rl = (m_relu != 0); mp = (m_mp != 0);
            if (m_zero != 0) dn = 1;
            else if (m_bias_done == 0) eb = 1;
            else if (m_work < m_n * m_s) begin
               p  = m_work / m_s;
               s  = m_work % m_s;
               st = 3'(s);
               for (int k = 0; k < 9; k++) begin
                  w[(8-k)*W_B +: W_B]  = W_B'(m_base + p + k % 3);
                  hh[(8-k)*H_B +: H_B] = H_B'((s + k / 3) % ROWS);
               end
               if (!h) begin er = 9'h1FF; ep = 1; end
            end else if (m_drain >= DRAIN) dn = 1;
         end
      end
      return {w, hh, er, eb, st, ep, st, bl, rl, mp, bz, dn, eo};
   endfunction

   task automatic model_advance();
      if (reset) begin
         m_active = 0; m_err_pend = 0;
      end else if (m_active == 0) begin
         m_err_pend = 0;
         if (start) begin
            if (int'(cfg_base_w) + int'(cfg_num_out) + 1 > COLS - 1) m_err_pend = 1;
            else begin
               m_active = 1; m_bias_done = 0; m_work = 0; m_drain = 0;
               m_base = int'(cfg_base_w); m_n = int'(cfg_num_out); m_s = int'(cfg_steps) + 1;
               m_bound = int'(cfg_bound); m_relu = int'(cfg_relu); m_mp = int'(cfg_mp);
               m_zero = (m_n == 0) ? 1 : 0;
            end
         end
      end else begin
         if (m_zero != 0) m_active = 0;
         else if (m_bias_done == 0) m_bias_done = 1;
         else if (m_work < m_n * m_s) begin
            if (!hold) m_work++;
         end else if (m_drain < DRAIN) m_drain++;
         else m_active = 0;
      end
   endtask

   task automatic clear_trace();
      cyc = 0; pe_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
      done_at = -1; err_at = -1;
   endtask

   // one clock: sample at negedge against the model, then let the model take the edge
   task automatic tick();
      logic [VW-1:0] e;
      @(negedge clk);
      exp_q.push_back(model_out(reset, hold));
      if (cyc < TR) begin
         tr_w[cyc] = readi_w; tr_h[cyc] = readi_h; tr_pe[cyc] = en_pe;
         tr_bias[cyc] = en_bias; tr_act[cyc] = act; tr_state[cyc] = state_dbg;
      end
      pe_cnt   += int'(en_pe);
      rd_cnt   += int'(en_read != 9'h000);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      err_cnt  += int'(err);
      if (done && done_at < 0) done_at = cyc;
      if (err && err_at < 0) err_at = cyc;
      e = exp_q.pop_front();
      check($sformatf("cycle%0d_outputs", total_cyc), 128'(act), 128'(e));
      @(posedge clk);
      model_advance();
      #1;
      cyc++;
      total_cyc++;
   endtask

   task automatic set_cfg(input int base, input int n, input int steps);
      cfg_base_w  = W_B'(base);
      cfg_num_out = W_B'(n);
      cfg_steps   = 3'(steps);
      cfg_bound   = 3'(base + n + steps);
      cfg_relu    = 1'b1;
      cfg_mp      = 1'(n);
   endtask

   task automatic run_job(input int base, input int n, input int steps,
                          input int hold_from, input int hold_len, input int mid_at);
      bit ended;
      clear_trace();
      set_cfg(base, n, steps);
      start = 1'b1; hold = 1'b0;
      tick();
      start = 1'b0;
      ended = 0;
      for (int c = 1; c < 300 && !ended; c++) begin
         hold = (c >= hold_from) && (c < hold_from + hold_len);
         if (c == mid_at) begin
            start = 1'b1;
            cfg_base_w = W_B'(20); cfg_num_out = W_B'(5); cfg_steps = 3'd4;
            cfg_bound = 3'd6; cfg_relu = ~cfg_relu; cfg_mp = ~cfg_mp;
         end
         tick();
         start = 1'b0;
         if (m_active == 0 && m_err_pend == 0) ended = 1;
      end
      hold = 1'b0;
      if (!ended) begin
         n_checks++; n_err++;
         $display("FAIL job_timeout: got busy after 300 cycles expected idle");
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hold = 1'b0;
      set_cfg(0, 0, 0);
      tbl[0] = '{0, 2, 1, 10, 4, 1, 0, 10, -1};
      tbl[1] = '{77, 2, 0, 0, 0, 0, 1, -1, 1};
      tbl[2] = '{5, 0, 3, 1, 0, 1, 0, 1, -1};
      tbl[3] = '{76, 2, 0, 8, 2, 1, 0, 8, -1};
      tbl[4] = '{10, 3, 7, 30, 24, 1, 0, 30, -1};
      tbl[5] = '{79, 0, 0, 0, 0, 0, 1, -1, 1};
      tbl[6] = '{0, 78, 0, 84, 78, 1, 0, 84, -1};
      tbl[7] = '{1, 78, 0, 0, 0, 0, 1, -1, 1};

      @(posedge clk); #1;
      clear_trace();
      tick(); tick();
      reset = 1'b0;
      clear_trace();
      tick();
      check("reset_outputs_zero", 128'(tr_act[0]), 128'(0));
      check("reset_state_idle", 128'(tr_state[0]), 128'(0));

      // job table
      for (int i = 0; i < 8; i++) begin
         run_job(tbl[i].base, tbl[i].n, tbl[i].steps, -1, 0, -1);
         check($sformatf("job%0d_busy_cycles", i), 128'(busy_cnt), 128'(tbl[i].busy_c));
         check($sformatf("job%0d_pe_cycles", i), 128'(pe_cnt), 128'(tbl[i].pe_c));
         check($sformatf("job%0d_read_cycles", i), 128'(rd_cnt), 128'(tbl[i].pe_c));
         check($sformatf("job%0d_done_count", i), 128'(done_cnt), 128'(tbl[i].done_c));
         check($sformatf("job%0d_err_count", i), 128'(err_cnt), 128'(tbl[i].err_c));
         check($sformatf("job%0d_done_at", i), 128'(done_at), 128'(tbl[i].done_at));
         check($sformatf("job%0d_err_at", i), 128'(err_at), 128'(tbl[i].err_at));
      end

      // basic job: window details at (p,s)=(1,1)
      run_job(0, 2, 1, -1, 0, -1);
      check("basic_bias_cycle1", 128'(tr_bias[1]), 128'(1));
      check("basic_lane4_w", 128'(tr_w[5][4*W_B +: W_B]), 128'(2));
      check("basic_lane4_h", 128'(tr_h[5][4*H_B +: H_B]), 128'(2));

      // stall at (0,1) for three cycles
      run_job(0, 2, 1, 3, 3, -1);
      for (int c = 3; c < 6; c++) check($sformatf("stall_pe_low%0d", c), 128'(tr_pe[c]), 128'(0));
      for (int c = 3; c < 7; c++) begin
         check($sformatf("stall_lane0_w%0d", c), 128'(tr_w[c][8*W_B +: W_B]), 128'(0));
         check($sformatf("stall_lane8_h%0d", c), 128'(tr_h[c][0 +: H_B]), 128'(3));
      end
      check("stall_pe_total", 128'(pe_cnt), 128'(4));
      check("stall_done_at", 128'(done_at), 128'(13));

      // start while busy is dropped
      run_job(3, 2, 1, -1, 0, 3);
      check("busy_start_lane0_w", 128'(tr_w[4][8*W_B +: W_B]), 128'(4));
      check("busy_start_pe_total", 128'(pe_cnt), 128'(4));
      check("busy_start_done_at", 128'(done_at), 128'(10));

      // reset in the middle of RUN at (1,0), restart immediately
      clear_trace();
      set_cfg(0, 2, 1);
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("midrun_reset_no_done", 128'(done_cnt), 128'(0));
      clear_trace();
      start = 1'b1; tick(); start = 1'b0;
      check("post_reset_outputs_zero", 128'(tr_act[0]), 128'(0));
      check("post_reset_state_idle", 128'(tr_state[0]), 128'(0));
      for (int c = 0; c < 40 && (m_active != 0); c++) tick();
      check("post_reset_done_count", 128'(done_cnt), 128'(1));
      check("post_reset_pe_total", 128'(pe_cnt), 128'(4));
      check("post_reset_done_at", 128'(done_at), 128'(10));

      // random traffic against the model
      for (int j = 0; j < 40; j++) begin
         set_cfg(($urandom_range(0, 3) == 0) ? $urandom_range(70, 79) : $urandom_range(0, 60),
                 $urandom_range(0, 6), $urandom_range(0, 7));
         cfg_relu = 1'($urandom_range(0, 1));
         start = 1'b1; hold = 1'($urandom_range(0, 1));
         tick();
         start = 1'b0;
         for (int c = 0; c < 150; c++) begin
            hold  = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 9) == 0);
            if (start) set_cfg($urandom_range(0, 79), $urandom_range(0, 6), $urandom_range(0, 7));
            reset = ($urandom_range(0, 79) == 0);
            tick();
            reset = 1'b0; start = 1'b0;
            if (m_active == 0 && m_err_pend == 0) break;
         end
         hold = 1'b0;
      end
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/npu_sequencer.md
NPU_SEQUENCER -- requirements
Module: npu_sequencer

Interface
REQ-001 SHALL have parameter width, default 80, meaning number of feature-map columns in memory.
REQ-002 SHALL have parameter height, default 8, meaning number of feature-map rows in memory.
REQ-003 SHALL have parameter width_b, default 7, meaning column-address width.
REQ-004 SHALL have parameter height_b, default 3, meaning row-address width.
REQ-005 SHALL have parameter DRAIN_CYC, default 4, meaning cycles waited after the last read for the datapath to flush.
REQ-006 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  meaning a job-request pulse, sampled only in IDLE.
REQ-009 SHALL have port hold  input  1  meaning a stall request during RUN.
REQ-010 SHALL have port cfg_base_w  input  width_b  meaning first output column.
REQ-011 SHALL have port cfg_num_out  input  width_b  meaning number of output positions N.
REQ-012 SHALL have port cfg_steps  input  3  meaning accumulation steps S = cfg_steps+1.
REQ-013 SHALL have ports cfg_bound (input, 3 bits), cfg_relu (input, 1 bit) and cfg_mp (input, 1 bit), meaning the bound level, ReLU enable and max-pool enable.
REQ-014 SHALL have port readi_w  output  width_b*9  meaning the per-lane column address; lane 0 is the MSB slice.
REQ-015 SHALL have port readi_h  output  height_b*9  meaning the per-lane row address; lane 0 is the MSB slice.
REQ-016 SHALL have ports en_read (output, 9 bits), en_bias (output, 1 bit), step (output, 3 bits), en_pe (output, 1 bit), step_p (output, 3 bits), bound_level (output, 3 bits), en_relu (output, 1 bit) and en_mp (output, 1 bit), meaning the datapath controls.
REQ-017 SHALL have ports busy (output, 1 bit), done (output, 1 bit) and err (output, 1 bit), meaning the job status.

Function
REQ-018 SHALL implement the states IDLE, BIAS, RUN, DRAIN and DONE, with all outputs decoded from registered state and counters.
REQ-019 SHALL, on start=1 in IDLE, latch all cfg_* inputs, clear p (position) and s (step), and apply the first matching rule: err case -> IDLE; N=0 -> DONE; else -> BIAS.
REQ-020 SHALL treat a job as an err case when cfg_base_w + N + 1 > width-1, and SHALL then pulse err=1 for exactly 1 cycle, leave busy=0, and not assert done.
REQ-021 SHALL, in BIAS (1 cycle), drive en_bias=1 and step=0, then move to RUN.
REQ-022 SHALL, in RUN with hold=0, drive en_read=9'h1FF, en_pe=1, step=s and step_p=s.
REQ-023 SHALL, in RUN with hold=0, drive lane k (0..8) as readi_w = cfg_base_w + p + (k mod 3) and readi_h = (s + k div 3) mod height.
REQ-024 SHALL, in RUN with hold=0, advance as follows: s increments; when s=S-1, s->0 and p increments; when p=N-1 and s=S-1, move to DRAIN.
REQ-025 SHALL, in RUN with hold=1, freeze p, s and the state, and drive en_read=0 and en_pe=0 with addresses held.
REQ-026 SHALL, in DRAIN, count DRAIN_CYC cycles with en_read=0 and en_pe=0, then move to DONE.
REQ-027 SHALL, in DONE, pulse done=1 for 1 cycle, then move to IDLE.
REQ-028 SHALL drive busy=1 in BIAS, RUN, DRAIN and DONE, and busy=0 in IDLE.
REQ-029 SHALL drive bound_level, en_relu and en_mp from the latched config while busy=1, and 0 while busy=0.
REQ-030 SHALL ignore start while busy=1, with no re-latch of config.
REQ-031 SHALL ignore hold outside RUN.
REQ-032 SHALL make the total RUN cycles with en_pe=1 exactly N*S, independent of any hold pattern.
REQ-033 SHALL, in IDLE, BIAS, DRAIN and DONE, drive en_read=0, en_pe=0 and all addresses 0; step and step_p SHALL be 0 except step=0 in BIAS per REQ-021.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, go to IDLE and clear p, s, the drain counter and the latched config, regardless of the current state.
REQ-035 SHALL hold every output at 0 while reset=1 and in the first cycle after reset.
REQ-036 SHALL, when reset occurs mid-RUN, not pulse done; a new start SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-037 SHALL verify basic: base=0, N=2, S=2 (cfg_steps=1) -> BIAS 1 cycle; RUN 4 cycles with (p,s)=(0,0),(0,1),(1,0),(1,1); lane 4 at (1,1) is readi_w=2, readi_h=2; DRAIN 4 cycles; done 1 cycle; busy high for 10 cycles.
REQ-038 SHALL verify stall: the basic job with hold=1 for 3 cycles at RUN (0,1) -> en_pe low for those 3 cycles, address unchanged, exactly 4 en_pe cycles, done 3 cycles later than in basic.
REQ-039 SHALL verify range error: base=77, N=2 -> err pulse 1 cycle, busy stays 0, no en_read, no done.
REQ-040 SHALL verify zero-length job: N=0 -> no BIAS/RUN, done pulses the cycle after start, busy high for 1 cycle.
REQ-041 SHALL verify start while busy: a second start mid-RUN with different cfg -> ignored; addresses continue from the first cfg.
REQ-042 SHALL verify reset mid-RUN: reset at (1,0) -> next cycle all outputs 0 and state IDLE; a fresh start completes normally with a single done.
